// File: rtl/sram_ctrl_pkg.sv
// Shared widths and power-state encoding for the SRAM port arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 11;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_DEPTH  = 2048;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } pwr_state_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side request/response bundle for the SRAM port arbiter.
// Latency: read response one cycle after the request transfer.
// Backpressure: req_ready per requester; valid held until its transfer.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    import sram_ctrl_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ*SRAM_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*SRAM_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [SRAM_DATA_W-1:0]         resp_rdata;

    // Requesters drive the request fields and observe grant/response.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    // The arbiter consumes requests and produces grant/response.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; search starts just after the last winner.
// Latency: combinational grant; pointer moves on the edge after a transfer.
// Backpressure: pointer only advances when the caller signals a transfer.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int              PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

    // ptr is the first requester searched, i.e. (last winner + 1) mod N.
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;

    // Rotate the search from ptr and take the first active request.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
    end

    // Move the search start past the winner only when the grant was used.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between NUM_REQ requesters, with retention sleep.
// Latency: request drives the macro combinationally; read data one cycle after transfer.
// Backpressure: one req_ready per cycle; none while asleep, waking, entering sleep or in reset.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int         NUM_REQ     = 2,
    parameter int         WAKE_CYCLES = 2,
    parameter logic [2:0] EMA_VAL     = 3'b000
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_port_arbiter_if.slave     req_if,
    input  logic                   sleep_req,
    output logic                   sleep_ack,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_d,
    output logic [2:0]             sram_ema,
    output logic                   sram_retn,
    input  logic [SRAM_DATA_W-1:0] sram_q
);

    // Final wake count; unused when WAKE_CYCLES is 0 because SLEEP skips WAKE.
    localparam logic [3:0] WAKE_LAST = (WAKE_CYCLES == 0) ? 4'd0 : 4'(WAKE_CYCLES - 1);

    pwr_state_t             state;
    pwr_state_t             state_nxt;
    logic [3:0]             wake_cnt;
    logic                   grant_en;
    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     resp_q;
    logic                   xfer;
    logic                   sel_we;
    logic [SRAM_ADDR_W-1:0] sel_addr;
    logic [SRAM_DATA_W-1:0] sel_wdata;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [SRAM_DATA_W-1:0] d_q;

    // Requests reach the arbiter only when the power FSM allows a grant.
    assign arb_req = req_if.req_valid & {NUM_REQ{grant_en}};
    assign xfer    = |grant;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (xfer),
        .grant   (grant)
    );

    // Power state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACTIVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and power-side outputs; sleep_req in ACTIVE blocks the grant that cycle.
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        sram_retn = 1'b1;
        sleep_ack = 1'b0;
        unique case (state)
            ACTIVE: begin
                if (sleep_req) begin
                    state_nxt = SLEEP;
                end else begin
                    grant_en = ~rst;
                end
            end
            SLEEP: begin
                sram_retn = 1'b0;
                sleep_ack = 1'b1;
                if (!sleep_req) begin
                    state_nxt = (WAKE_CYCLES == 0) ? ACTIVE : WAKE;
                end
            end
            WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = ACTIVE;
                end
            end
            default: state_nxt = ACTIVE;
        endcase
        if (rst) begin
            sram_retn = 1'b1;
        end
    end

    // Wake timer: zero outside WAKE so each wake starts from a cleared count.
    always_ff @(posedge clk) begin
        if (rst || state != WAKE) begin
            wake_cnt <= '0;
        end else begin
            wake_cnt <= wake_cnt + 1'b1;
        end
    end

    // Route the winner's fields to the macro; keep the last address/data when idle.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = addr_q;
        sel_wdata = d_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_if.req_we[i];
                sel_addr  = req_if.req_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W];
                sel_wdata = req_if.req_wdata[i*SRAM_DATA_W +: SRAM_DATA_W];
            end
        end
    end

    // Remember the last driven address/data so the macro pins stay quiet when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            d_q    <= '0;
        end else if (xfer) begin
            addr_q <= sel_addr;
            d_q    <= sel_wdata;
        end
    end

    // A granted read owes its requester a response in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= '0;
        end else begin
            resp_q <= grant & ~req_if.req_we;
        end
    end

    assign sram_cen  = ~xfer;
    assign sram_wen  = ~(xfer & sel_we);
    assign sram_addr = sel_addr;
    assign sram_d    = sel_wdata;
    assign sram_ema  = EMA_VAL;

    // Reset in the response cycle cancels the response.
    assign req_if.req_ready  = grant;
    assign req_if.resp_valid = resp_q & {NUM_REQ{~rst}};
    assign req_if.resp_rdata = sram_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a cycle-level reference model.
// Latency: checks every cycle at the falling edge; model advances at the rising edge.
// Backpressure: requesters hold requests until the model predicts their grant.
module tb_sram_port_arbiter;

    localparam int         NR  = 2;
    localparam int         WC  = 2;
    localparam logic [2:0] EMA = 3'b101;

    localparam int M_ACTIVE = 0;
    localparam int M_SLEEP  = 1;
    localparam int M_WAKE   = 2;

    logic        clk;
    logic        rst;
    logic        sleep_req;
    logic        sleep_ack;
    logic        sram_cen;
    logic        sram_wen;
    logic [10:0] sram_addr;
    logic [31:0] sram_d;
    logic [2:0]  sram_ema;
    logic        sram_retn;
    logic [31:0] sram_q;

    sram_port_arbiter_if #(.NUM_REQ(NR)) bus ();

    sram_port_arbiter #(
        .NUM_REQ     (NR),
        .WAKE_CYCLES (WC),
        .EMA_VAL     (EMA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_if    (bus),
        .sleep_req (sleep_req),
        .sleep_ack (sleep_ack),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_d    (sram_d),
        .sram_ema  (sram_ema),
        .sram_retn (sram_retn),
        .sram_q    (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port macro: registered read, write at the edge.
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_d;
            else           sram_q <= mem[sram_addr];
        end
    end

    // Reference model state.
    int          n_checks;
    int          n_errors;
    int          mode;
    int          wake_left;
    int          rr_next;
    int          resp_idx;
    logic [31:0] resp_data;
    bit          resp_known;
    logic [31:0] shadow [0:2047];
    bit          written [0:2047];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic issue(int i, logic we, logic [10:0] a, logic [31:0] d);
        bus.req_valid[i]         = 1'b1;
        bus.req_we[i]            = we;
        bus.req_addr[i*11 +: 11] = a;
        bus.req_wdata[i*32 +: 32] = d;
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic step();
        logic [NR-1:0] exp_rdy;
        logic [10:0]   a;
        logic [31:0]   d;
        logic          we;
        int            g;
        @(negedge clk);
        g  = -1;
        a  = '0;
        d  = '0;
        we = 1'b0;
        if (!rst && mode == M_ACTIVE && !sleep_req) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (rr_next + k) % NR;
                if (g < 0 && bus.req_valid[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            a  = bus.req_addr[g*11 +: 11];
            d  = bus.req_wdata[g*32 +: 32];
            we = bus.req_we[g];
        end
        check("req_ready", bus.req_ready, exp_rdy);
        check("sram_cen", sram_cen, (g < 0));
        check("sram_wen", sram_wen, !(g >= 0 && we));
        check("sram_retn", sram_retn, (rst || mode != M_SLEEP));
        check("sleep_ack", sleep_ack, (mode == M_SLEEP));
        check("sram_ema", sram_ema, EMA);
        if (g >= 0) check("sram_addr", sram_addr, a);
        if (g >= 0 && we) check("sram_d", sram_d, d);
        if (!rst && resp_idx >= 0) begin
            check("resp_valid", bus.resp_valid, (1 << resp_idx));
            if (resp_known) check("resp_rdata", bus.resp_rdata, resp_data);
        end else begin
            check("resp_valid", bus.resp_valid, 0);
        end
        @(posedge clk);
        if (rst) begin
            mode      = M_ACTIVE;
            rr_next   = 0;
            resp_idx  = -1;
            wake_left = 0;
        end else begin
            resp_idx = -1;
            if (g >= 0) begin
                if (we) begin
                    shadow[a]  = d;
                    written[a] = 1'b1;
                end else begin
                    resp_idx   = g;
                    resp_data  = shadow[a];
                    resp_known = written[a];
                end
                rr_next = (g + 1) % NR;
            end
            case (mode)
                M_ACTIVE: if (sleep_req) mode = M_SLEEP;
                M_SLEEP: if (!sleep_req) begin
                    if (WC == 0) mode = M_ACTIVE;
                    else begin
                        mode      = M_WAKE;
                        wake_left = WC;
                    end
                end
                default: begin
                    wake_left--;
                    if (wake_left == 0) mode = M_ACTIVE;
                end
            endcase
        end
        #1;
        if (g >= 0) bus.req_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(int i);
        for (int n = 0; n < 40; n++) begin
            if (!bus.req_valid[i]) return;
            step();
        end
        check("grant_timeout", bus.req_valid[i], 1'b0);
    endtask

    initial begin
        logic [10:0] pool [0:7];
        n_checks  = 0;
        n_errors  = 0;
        mode      = M_ACTIVE;
        wake_left = 0;
        rr_next   = 0;
        resp_idx  = -1;
        resp_known = 1'b0;
        resp_data = '0;
        for (int i = 0; i < 2048; i++) begin
            shadow[i]  = '0;
            written[i] = 1'b0;
        end
        pool = '{11'h000, 11'h7FF, 11'h00F, 11'h010, 11'h011, 11'h123, 11'h400, 11'h3FF};
        rst           = 1'b1;
        sleep_req     = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        step();
        step();
        rst = 1'b0;

        // Idle: macro stays deselected.
        repeat (3) step();

        // Write then read back through requester 0.
        issue(0, 1'b1, 11'h00F, 32'h0000_000E);
        wait_idle(0);
        issue(0, 1'b0, 11'h00F, 32'h0);
        wait_idle(0);
        step();

        // Preload, then both requesters read continuously.
        for (int k = 0; k < 6; k++) begin
            issue(0, 1'b1, 11'(11'h020 + k), 32'hA000_0000 + k);
            wait_idle(0);
        end
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NR; i++)
                if (!bus.req_valid[i]) issue(i, 1'b0, 11'(11'h020 + ((k + i) % 6)), 32'h0);
            step();
        end
        wait_idle(0);
        wait_idle(1);
        step();

        // Sleep wins over a pending request; data retained across sleep.
        issue(0, 1'b1, 11'h7FF, 32'hDEAD_BEEF);
        wait_idle(0);
        issue(1, 1'b0, 11'h7FF, 32'h0);
        sleep_req = 1'b1;
        repeat (4) step();
        sleep_req = 1'b0;
        wait_idle(1);
        step();

        // Address extremes hold distinct values.
        issue(0, 1'b1, 11'h000, 32'h1234_5678);
        wait_idle(0);
        issue(1, 1'b1, 11'h7FF, 32'h8765_4321);
        wait_idle(1);
        issue(0, 1'b0, 11'h7FF, 32'h0);
        issue(1, 1'b0, 11'h000, 32'h0);
        wait_idle(0);
        wait_idle(1);
        step();

        // Reset right after a read grant cancels its response and rewinds priority.
        issue(0, 1'b0, 11'h00F, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        issue(0, 1'b0, 11'h010, 32'h0);
        issue(1, 1'b0, 11'h011, 32'h0);
        wait_idle(0);
        wait_idle(1);
        step();

        // Randomized traffic with sleep toggling and occasional resets.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NR; i++)
                if (!bus.req_valid[i] && ($urandom % 3) == 0)
                    issue(i, 1'($urandom % 2), pool[$urandom_range(0, 7)], $urandom);
            if (($urandom % 25) == 0) sleep_req = ~sleep_req;
            rst = (($urandom % 150) == 0);
            step();
        end
        rst       = 1'b0;
        sleep_req = 1'b0;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
